// File: rtl/ptw_walker.sv
// ptw_walker: two-level page-table walker that answers TLB miss requests over a single-outstanding read port
module ptw_walker #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] root_ppn_i,
  input  logic        ptw_req_i,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  output logic [31:0] ptw_pte_o,
  output logic        ptw_fault_o,
  output logic        ptw_busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);
  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP} state_t;
  state_t state;
  logic [9:0] vpn0;
  logic [CNT_W-1:0] cnt;
  logic stale;
  logic l1, leaf, bad, descend, good, timeout, unused_bits;
  logic [31:0] pte_now;
  assign l1 = state == L1_WAIT;
  assign leaf = mem_rdata_i[3];
  assign bad = mem_err_i || !mem_rdata_i[2] || (l1 && leaf && mem_rdata_i[21:12] != '0);
  assign descend = l1 && !leaf && !bad;
  assign good = mem_rvalid_i && !bad;
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign pte_now = l1 ? {mem_rdata_i[31:22], vpn0, 10'b0, mem_rdata_i[1:0]}
                      : {mem_rdata_i[31:12], 10'b0, mem_rdata_i[1:0]};
  assign unused_bits = ^{ptw_vaddr_i[11:0], mem_rdata_i[11:4]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vpn0 <= '0;
      cnt <= '0;
      stale <= 1'b0;
      ptw_resp_valid_o <= 1'b0;
      ptw_pte_o <= '0;
      ptw_fault_o <= 1'b0;
      ptw_busy_o <= 1'b0;
      mem_req_o <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      ptw_resp_valid_o <= 1'b0;
      if (stale && mem_rvalid_i) stale <= 1'b0;
      case (state)
        IDLE: if (ptw_req_i) begin
          state <= L1_REQ;
          vpn0 <= ptw_vaddr_i[21:12];
          ptw_busy_o <= 1'b1;
          mem_req_o <= !stale || mem_rvalid_i;
          mem_addr_o <= {root_ppn_i, ptw_vaddr_i[31:22], 2'b00};
        end
        L1_REQ, L0_REQ: if (mem_req_o && mem_ready_i) begin
          mem_req_o <= 1'b0;
          cnt <= '0;
          state <= state == L1_REQ ? L1_WAIT : L0_WAIT;
        end else mem_req_o <= !stale || mem_rvalid_i;
        L1_WAIT, L0_WAIT: if (mem_rvalid_i && descend) begin
          state <= L0_REQ;
          mem_req_o <= 1'b1;
          mem_addr_o <= {mem_rdata_i[31:12], vpn0, 2'b00};
        end else if (mem_rvalid_i || timeout) begin
          // a timed-out read may still answer later; stale swallows that beat
          state <= RESP;
          ptw_resp_valid_o <= 1'b1;
          ptw_fault_o <= !good;
          ptw_pte_o <= good ? pte_now : '0;
          stale <= !mem_rvalid_i;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          state <= IDLE;
          ptw_busy_o <= 1'b0;
          ptw_fault_o <= 1'b0;
          ptw_pte_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ptw_walker.sv
// tb_ptw_walker: directed walks against a page-table memory model and a spec-level response predictor
module tb_ptw_walker;
  logic clk = 1'b0;
  logic rst_n;
  logic [19:0] root_ppn_i;
  logic ptw_req_i;
  logic [31:0] ptw_vaddr_i;
  logic ptw_resp_valid_o;
  logic [31:0] ptw_pte_o;
  logic ptw_fault_o;
  logic ptw_busy_o;
  logic mem_req_o;
  logic [31:0] mem_addr_o;
  logic mem_ready_i;
  logic mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic mem_err_i;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [logic [31:0]];
  int reads = 0;
  int walk_base = 0;
  int ready_lat = 0;
  int err_lvl = 0;
  int drop_lvl = 0;
  int late_req = 0;
  logic [32:0] expq [$];
  logic [31:0] last_pte;
  logic last_fault;

  ptw_walker #(.TIMEOUT_CYCLES(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .root_ppn_i(root_ppn_i), .ptw_req_i(ptw_req_i),
    .ptw_vaddr_i(ptw_vaddr_i), .ptw_resp_valid_o(ptw_resp_valid_o), .ptw_pte_o(ptw_pte_o),
    .ptw_fault_o(ptw_fault_o), .ptw_busy_o(ptw_busy_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [19:0] root, input logic [31:0] va);
    logic [31:0] a, e;
    a = {root, va[31:22], 2'b00};
    e = mem.exists(a) ? mem[a] : 32'h0;
    if (err_lvl == 1 || drop_lvl == 1 || !e[2]) return {1'b1, 32'h0};
    if (e[3]) return (e[21:12] != 10'h0) ? {1'b1, 32'h0} : {1'b0, e[31:22], va[21:12], 10'h0, e[1:0]};
    a = {e[31:12], va[21:12], 2'b00};
    e = mem.exists(a) ? mem[a] : 32'h0;
    if (err_lvl == 2 || drop_lvl == 2 || !e[2]) return {1'b1, 32'h0};
    return {1'b0, e[31:12], 10'h0, e[1:0]};
  endfunction

  initial begin : responder
    logic pend, last_req, last_rdy;
    logic [31:0] last_addr, cur_addr;
    int rdy_wait, late_done, lvl;
    pend = 0; last_req = 0; last_rdy = 0; last_addr = 0; cur_addr = 0;
    rdy_wait = 0; late_done = 0; lvl = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
    forever begin
      @(negedge clk);
      mem_ready_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
      if (!rst_n) begin
        pend = 0; rdy_wait = 0; last_req = 0;
        continue;
      end
      if (last_req && !last_rdy) begin
        check("req_held", 32'(mem_req_o), 32'd1);
        check("addr_stable", mem_addr_o, last_addr);
      end
      if (late_req != late_done) begin
        late_done++;
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0005;
      end else if (pend) begin
        pend = 0;
        mem_rvalid_i = 1;
        mem_rdata_i = mem.exists(cur_addr) ? mem[cur_addr] : 32'h0;
        mem_err_i = (lvl == err_lvl);
      end
      if (mem_req_o && !pend) begin
        if (rdy_wait < ready_lat) rdy_wait++;
        else begin
          rdy_wait = 0; mem_ready_i = 1; reads++;
          lvl = reads - walk_base; cur_addr = mem_addr_o; pend = (lvl != drop_lvl);
        end
      end
      last_req = mem_req_o; last_rdy = mem_ready_i; last_addr = mem_addr_o;
    end
  end

  initial begin : scoreboard
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (ptw_resp_valid_o) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp got=%h exp=none", ptw_pte_o);
        end else begin
          e = expq.pop_front();
          check("resp_pte", ptw_pte_o, e[31:0]);
          check("resp_fault", 32'(ptw_fault_o), 32'(e[32]));
          check("busy_at_resp", 32'(ptw_busy_o), 32'd1);
        end
      end
    end
  end

  task automatic walk(input logic [19:0] root, input logic [31:0] va, input int exp_lat, input bit dup, input int late_at);
    int lat;
    bit got;
    @(negedge clk);
    walk_base = reads;
    expq.push_back(model(root, va));
    root_ppn_i = root; ptw_vaddr_i = va; ptw_req_i = 1;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      ptw_req_i = dup && lat == 2;
      if (dup && lat == 2) ptw_vaddr_i = 32'hFFC0_0000;
      if (late_at > 0 && lat < late_at) check("stale_no_req", 32'(mem_req_o), 32'd0);
      if (lat == late_at) late_req++;
      if (ptw_resp_valid_o) begin
        got = 1; last_pte = ptw_pte_o; last_fault = ptw_fault_o;
      end
    end
    check("resp_seen", 32'(got), 32'd1);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
  endtask

  initial begin
    rst_n = 0; ptw_req_i = 0; ptw_vaddr_i = 0; root_ppn_i = 0;
    repeat (3) @(negedge clk);
    check("reset_flags", {28'h0, ptw_resp_valid_o, ptw_fault_o, ptw_busy_o, mem_req_o}, 32'h0);
    check("reset_pte", ptw_pte_o, 32'h0);
    check("reset_addr", mem_addr_o, 32'h0);
    rst_n = 1;
    mem[32'h0008_0004] = 32'h0009_0004;
    mem[32'h0009_000C] = 32'h1234_5007;
    walk(20'h00080, 32'h0040_3123, 5, 0, 0);
    check("t1_pte", last_pte, 32'h1234_5003);
    check("t1_fault", 32'(last_fault), 32'd0);
    check("t1_reads", reads - walk_base, 2);
    mem[32'h0008_0004] = 32'hABC0_000D;
    walk(20'h00080, 32'h0040_3123, 3, 0, 0);
    check("t2_pte", last_pte, 32'hABC0_3001);
    check("t2_reads", reads - walk_base, 1);
    mem[32'h0008_0004] = 32'hABC0_100D;
    walk(20'h00080, 32'h0040_3123, 3, 0, 0);
    check("t2_misaligned_fault", 32'(last_fault), 32'd1);
    check("t2_misaligned_pte", last_pte, 32'h0);
    mem[32'h0008_0004] = 32'h0009_0000;
    walk(20'h00080, 32'h0040_3123, 3, 0, 0);
    check("t3_l1_fault", 32'(last_fault), 32'd1);
    check("t3_l1_reads", reads - walk_base, 1);
    mem[32'h0008_0004] = 32'h0009_0004;
    mem[32'h0009_000C] = 32'h1234_5003;
    walk(20'h00080, 32'h0040_3123, 5, 0, 0);
    check("t3_l0_fault", 32'(last_fault), 32'd1);
    mem[32'h0009_000C] = 32'h1234_5007;
    ready_lat = 7; err_lvl = 2;
    walk(20'h00080, 32'h0040_3123, 19, 0, 0);
    check("t4_err_fault", 32'(last_fault), 32'd1);
    check("t4_err_pte", last_pte, 32'h0);
    ready_lat = 0; err_lvl = 0;
    drop_lvl = 1;
    walk(20'h00080, 32'h0040_3123, 18, 0, 0);
    check("t5_timeout_fault", 32'(last_fault), 32'd1);
    drop_lvl = 0;
    walk(20'h00080, 32'h0040_3123, -1, 0, 4);
    check("t5_after_stale_pte", last_pte, 32'h1234_5003);
    check("t5_after_stale_reads", reads - walk_base, 2);
    walk(20'h00080, 32'h0040_3123, 5, 1, 0);
    check("t6_dup_pte", last_pte, 32'h1234_5003);
    check("t6_dup_reads", reads - walk_base, 2);
    @(negedge clk);
    walk_base = reads; drop_lvl = 2;
    root_ppn_i = 20'h00080; ptw_vaddr_i = 32'h0040_3123; ptw_req_i = 1;
    @(negedge clk);
    ptw_req_i = 0;
    for (int i = 0; i < 50 && reads - walk_base < 2; i++) @(negedge clk);
    check("t6_l0_reached", reads - walk_base, 2);
    repeat (2) @(negedge clk);
    check("t6_pre_rst_busy", 32'(ptw_busy_o), 32'd1);
    check("t6_pre_rst_addr", mem_addr_o, 32'h0009_000C);
    #2 rst_n = 0;
    #1;
    check("t6_rst_flags", {28'h0, ptw_resp_valid_o, ptw_fault_o, ptw_busy_o, mem_req_o}, 32'h0);
    check("t6_rst_addr", mem_addr_o, 32'h0);
    check("t6_rst_pte", ptw_pte_o, 32'h0);
    drop_lvl = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    walk(20'h00080, 32'h0040_3123, 5, 0, 0);
    check("t6_post_rst_pte", last_pte, 32'h1234_5003);
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
